// File: rtl/watch_time_counter.sv
// watch_time_counter: calendar/time-of-day keeper, one second per clk1sec rise.
// Full Gregorian carry, validated loads from set-mode via {bin_time, en_time}.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   clk1sec   1 Hz square wave, asynchronous to clk
//   en_time   one-cycle load strobe
//   bin_time  {year[11:0],month,day,hour,minute,second} in binary
//   year..second  current calendar time (registered)
//   sec_tick  pulse the cycle after each second step
//   load_err  pulse the cycle after a rejected load
module watch_time_counter #(
  parameter logic [11:0] RST_YEAR  = 12'd2000,
  parameter logic [7:0]  RST_MONTH = 8'd1,
  parameter logic [7:0]  RST_DAY   = 8'd1,
  parameter logic [11:0] YEAR_MAX  = 12'd4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk1sec,
  input  logic        en_time,
  input  logic [51:0] bin_time,
  output logic [11:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic        sec_tick,
  output logic        load_err
);

  function automatic logic is_leap(
    input logic [11:0] y
  );
    logic d4;
    logic d100;
    logic d400;
    d4   = (y[1:0] == 2'b00);
    d100 = ((y % 12'd100) == 12'd0);
    d400 = ((y % 12'd400) == 12'd0);
    return (d4 && !d100) || d400;
  endfunction

  function automatic logic [7:0] max_date(
    input logic [7:0]  m,
    input logic [11:0] y
  );
    logic [7:0] r;
    case (m)
      8'd4, 8'd6,
      8'd9, 8'd11: r = 8'd30;
      8'd2:        r = 8'd28 + {7'd0, is_leap(y)};
      default:     r = 8'd31;
    endcase
    return r;
  endfunction

  // clk1sec synchroniser and rise detect
  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic w_inc;

  assign w_inc = r_s2 & ~r_s3;

  // current time
  logic [11:0] r_year;
  logic [7:0]  r_month;
  logic [7:0]  r_day;
  logic [7:0]  r_hour;
  logic [7:0]  r_min;
  logic [7:0]  r_sec;
  logic        r_sec_tick;
  logic        r_load_err;

  // load fields
  logic [11:0] w_ld_year;
  logic [7:0]  w_ld_month;
  logic [7:0]  w_ld_day;
  logic [7:0]  w_ld_hour;
  logic [7:0]  w_ld_min;
  logic [7:0]  w_ld_sec;
  logic [7:0]  w_ld_dim;
  logic        w_ld_valid;

  assign w_ld_year  = bin_time[51:40];
  assign w_ld_month = bin_time[39:32];
  assign w_ld_day   = bin_time[31:24];
  assign w_ld_hour  = bin_time[23:16];
  assign w_ld_min   = bin_time[15:8];
  assign w_ld_sec   = bin_time[7:0];

  assign w_ld_dim = max_date(w_ld_month, w_ld_year);

  assign w_ld_valid =
    (w_ld_year != 12'd0) &&
    (w_ld_year <= YEAR_MAX) &&
    (w_ld_month != 8'd0) &&
    (w_ld_month <= 8'd12) &&
    (w_ld_day != 8'd0) &&
    (w_ld_day <= w_ld_dim) &&
    (w_ld_hour <= 8'd23) &&
    (w_ld_min <= 8'd59) &&
    (w_ld_sec <= 8'd59);

  // next time after one second
  logic [11:0] w_nx_year;
  logic [7:0]  w_nx_month;
  logic [7:0]  w_nx_day;
  logic [7:0]  w_nx_hour;
  logic [7:0]  w_nx_min;
  logic [7:0]  w_nx_sec;
  logic [7:0]  w_dim;

  assign w_dim = max_date(r_month, r_year);

  always_comb begin
    w_nx_year  = r_year;
    w_nx_month = r_month;
    w_nx_day   = r_day;
    w_nx_hour  = r_hour;
    w_nx_min   = r_min;
    w_nx_sec   = r_sec;
    if (r_sec < 8'd59) begin
      w_nx_sec = r_sec + 8'd1;
    end else begin
      w_nx_sec = 8'd0;
      if (r_min < 8'd59) begin
        w_nx_min = r_min + 8'd1;
      end else begin
        w_nx_min = 8'd0;
        if (r_hour < 8'd23) begin
          w_nx_hour = r_hour + 8'd1;
        end else begin
          w_nx_hour = 8'd0;
          // >= keeps an out-of-range day from running away
          if (r_day < w_dim) begin
            w_nx_day = r_day + 8'd1;
          end else begin
            w_nx_day = 8'd1;
            if (r_month < 8'd12) begin
              w_nx_month = r_month + 8'd1;
            end else begin
              w_nx_month = 8'd1;
              if (r_year >= YEAR_MAX)
                w_nx_year = 12'd1;
              else
                w_nx_year = r_year + 12'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_year     <= RST_YEAR;
      r_month    <= RST_MONTH;
      r_day      <= RST_DAY;
      r_hour     <= 8'd0;
      r_min      <= 8'd0;
      r_sec      <= 8'd0;
      r_sec_tick <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_s1       <= clk1sec;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_sec_tick <= w_inc;
      r_load_err <= en_time & ~w_ld_valid;
      // a load (even a rejected one) swallows a coincident second
      if (en_time) begin
        if (w_ld_valid) begin
          r_year  <= w_ld_year;
          r_month <= w_ld_month;
          r_day   <= w_ld_day;
          r_hour  <= w_ld_hour;
          r_min   <= w_ld_min;
          r_sec   <= w_ld_sec;
        end
      end else if (w_inc) begin
        r_year  <= w_nx_year;
        r_month <= w_nx_month;
        r_day   <= w_nx_day;
        r_hour  <= w_nx_hour;
        r_min   <= w_nx_min;
        r_sec   <= w_nx_sec;
      end
    end
  end

  assign year     = r_year;
  assign month    = r_month;
  assign day      = r_day;
  assign hour     = r_hour;
  assign minute   = r_min;
  assign second   = r_sec;
  assign sec_tick = r_sec_tick;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_watch_time_counter.sv
// tb_watch_time_counter: scoreboard bench for watch_time_counter.
// Calendar reference model in plain arithmetic; monitor pops on DUT events.
module tb_watch_time_counter;

  typedef struct {
    int y;
    int mo;
    int d;
    int h;
    int mi;
    int s;
  } tm_t;

  typedef struct {
    string  nm;
    tm_t    t;
    bit     tick;
    bit     err;
    longint at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk1sec = 1'b0;
  logic        en_time = 1'b0;
  logic [51:0] bin_time = '0;
  logic [11:0] year;
  logic [7:0]  month;
  logic [7:0]  day;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic        sec_tick;
  logic        load_err;

  watch_time_counter dut (
    .clk      (clk),
    .rst      (rst),
    .clk1sec  (clk1sec),
    .en_time  (en_time),
    .bin_time (bin_time),
    .year     (year),
    .month    (month),
    .day      (day),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .sec_tick (sec_tick),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   probe = 0;
  bit   drain = 0;
  bit   drained = 0;
  tm_t  cur;

  // reference model
  function automatic bit leap(int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(int m, int y);
    int tbl[12] = '{31,28,31,30,31,30,31,31,30,31,30,31};
    if (m < 1 || m > 12) return 0;
    return tbl[m-1] + ((m == 2 && leap(y)) ? 1 : 0);
  endfunction

  function automatic tm_t adv(tm_t t);
    tm_t r;
    int  sod;
    r = t;
    sod = t.h * 3600 + t.mi * 60 + t.s + 1;
    if (sod == 86400) begin
      sod = 0;
      r.d = r.d + 1;
      if (r.d > dim(r.mo, r.y)) begin
        r.d = 1;
        r.mo = r.mo + 1;
        if (r.mo > 12) begin
          r.mo = 1;
          r.y = (r.y == 4095) ? 1 : r.y + 1;
        end
      end
    end
    r.h  = sod / 3600;
    r.mi = (sod / 60) % 60;
    r.s  = sod % 60;
    return r;
  endfunction

  function automatic bit valid(tm_t t);
    return t.y >= 1 && t.y <= 4095 &&
           t.mo >= 1 && t.mo <= 12 &&
           t.d >= 1 && t.d <= dim(t.mo, t.y) &&
           t.h < 24 && t.mi < 60 && t.s < 60;
  endfunction

  function automatic logic [51:0] pack(tm_t t);
    return {12'(t.y), 8'(t.mo), 8'(t.d), 8'(t.h), 8'(t.mi), 8'(t.s)};
  endfunction

  function automatic tm_t mk(int y, int mo, int d, int h, int mi, int s);
    tm_t t;
    t.y = y; t.mo = mo; t.d = d; t.h = h; t.mi = mi; t.s = s;
    return t;
  endfunction

  // monitor
  exp_t        e;
  logic [51:0] act;
  always @(negedge clk) begin
    act = {year, month, day, hour, minute, second};
    if (!rst && (sec_tick || load_err || probe)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d tick=%b err=%b time=%h",
                 cyc, sec_tick, load_err, act);
      end else begin
        e = expq.pop_front();
        if (cyc != e.at || sec_tick !== e.tick ||
            load_err !== e.err || act !== pack(e.t)) begin
          errors++;
          $display("FAIL %s cyc got %0d exp %0d tick got %b exp %b err got %b exp %b time got %h exp %h",
                   e.nm, cyc, e.at, sec_tick, e.tick, load_err, e.err,
                   act, pack(e.t));
        end
      end
    end
    if (drain && !drained) begin
      checks++;
      if (expq.size() != 0) begin
        errors++;
        $display("FAIL drain pending got %0d exp 0 first=%s",
                 expq.size(), expq[0].nm);
      end
      drained = 1;
    end
  end

  task automatic push(string nm, tm_t t, bit tick, bit err, longint at);
    exp_t x;
    x.nm = nm; x.t = t; x.tick = tick; x.err = err; x.at = at;
    expq.push_back(x);
  endtask

  task automatic sec_rise(string nm);
    longint n;
    @(posedge clk); #1;
    clk1sec = 1'b1;
    n = cyc;
    cur = adv(cur);
    push(nm, cur, 1'b1, 1'b0, n + 3);
    repeat (4) @(posedge clk);
    #1 clk1sec = 1'b0;
    repeat (3 + $urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic do_load(string nm, tm_t t);
    longint n;
    bit     ok;
    ok = valid(t);
    @(posedge clk); #1;
    en_time = 1'b1;
    bin_time = pack(t);
    n = cyc;
    if (ok) cur = t;
    push(nm, cur, 1'b0, !ok, n + 1);
    @(posedge clk); #1;
    en_time = 1'b0;
    probe = ok;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic collide(string nm, tm_t t);
    longint n;
    @(posedge clk); #1;
    clk1sec = 1'b1;
    n = cyc;
    repeat (2) @(posedge clk);
    #1;
    en_time = 1'b1;
    bin_time = pack(t);
    cur = t;
    push(nm, cur, 1'b1, 1'b0, n + 3);
    @(posedge clk); #1;
    en_time = 1'b0;
    repeat (2) @(posedge clk);
    #1 clk1sec = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_pulse(string nm, bit pending);
    @(posedge clk); #1;
    clk1sec = pending;
    @(posedge clk); #1;
    rst = 1'b1;
    clk1sec = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur = mk(2000, 1, 1, 0, 0, 0);
    push(nm, cur, 1'b0, 1'b0, cyc);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  function automatic tm_t rnd_valid();
    tm_t t;
    int  ys[5] = '{1900, 2000, 2024, 2100, 4095};
    t.y = ($urandom_range(0, 1) == 1) ? ys[$urandom_range(0, 4)]
                                      : int'($urandom_range(1, 4095));
    t.mo = $urandom_range(1, 12);
    t.d  = $urandom_range(1, dim(t.mo, t.y));
    t.h  = $urandom_range(0, 23);
    t.mi = $urandom_range(0, 59);
    t.s  = $urandom_range(0, 59);
    if ($urandom_range(0, 1) == 1) begin
      if ($urandom_range(0, 2) == 0) t.mo = 12;
      if ($urandom_range(0, 2) == 0) t.mo = 2;
      t.d = dim(t.mo, t.y);
      t.h = 23; t.mi = 59; t.s = 59;
    end
    return t;
  endfunction

  function automatic tm_t rnd_invalid();
    tm_t t;
    t = rnd_valid();
    case ($urandom_range(0, 5))
      0: t.y = 0;
      1: t.mo = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(13, 255));
      2: t.d = ($urandom_range(0, 1) == 1) ? 0
               : int'($urandom_range(dim(t.mo, t.y) + 1, 255));
      3: t.h = $urandom_range(24, 255);
      4: t.mi = $urandom_range(60, 255);
      default: t.s = $urandom_range(60, 255);
    endcase
    return t;
  endfunction

  initial begin
    cur = mk(2000, 1, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push("reset", cur, 1'b0, 1'b0, cyc);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
    repeat (3) @(posedge clk);

    sec_rise("first_sec");

    do_load("ld_2024_feb28", mk(2024, 2, 28, 23, 59, 59));
    sec_rise("leap_feb29");
    sec_rise("leap_feb29_s1");

    do_load("ld_2023_feb28", mk(2023, 2, 28, 23, 59, 59));
    sec_rise("nonleap_mar1");
    do_load("rej_1900_feb29", mk(1900, 2, 29, 0, 0, 0));

    do_load("ld_4095_dec31", mk(4095, 12, 31, 23, 59, 59));
    sec_rise("year_wrap");
    do_load("rej_apr31", mk(2021, 4, 31, 0, 0, 0));
    do_load("ld_2000_feb28", mk(2000, 2, 28, 23, 59, 59));
    sec_rise("leap_2000");

    collide("collide_load", mk(2022, 6, 15, 10, 20, 30));
    sec_rise("after_collide");

    reset_pulse("mid_reset", 1'b1);
    sec_rise("post_reset_sec");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: do_load("rnd_load", rnd_valid());
        1: do_load("rnd_reject", rnd_invalid());
        default: sec_rise("rnd_sec");
      endcase
    end

    repeat (2) @(posedge clk);
    #1 drain = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
